// File: rtl/alib_extmem_arb.sv
// Round-robin arbiter that shares one single-beat alib_extmem writer among NUM_REQ requesters.
// Each grant runs one init pulse, waits for done (or timeout), then returns a one-hot completion.
module alib_extmem_arb #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024,
   parameter int GW      = $clog2(NUM_REQ)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   output logic [NUM_REQ-1:0]    o_req_ready,
   input  logic [21*NUM_REQ-1:0] i_req_addr,
   input  logic [64*NUM_REQ-1:0] i_req_data,
   input  logic [31:0]           i_base_addr,
   output logic [NUM_REQ-1:0]    o_cpl_valid,
   output logic                  o_cpl_error,
   output logic [20:0]           o_wr_blockAddress,
   output logic [63:0]           o_wr_blockPayload,
   output logic [31:0]           o_wr_base_addr,
   output logic                  o_wr_init,
   input  logic                  i_wr_done,
   input  logic                  i_wr_error,
   output logic                  o_busy,
   output logic [GW-1:0]         o_grant_id,
   output logic                  o_timeout,
   output logic [31:0]           o_write_count
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CPL} state_t;

   state_t        state;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] winner;
   logic [CW-1:0] wait_cnt;
   logic [20:0]   sel_addr;
   logic [63:0]   sel_data;
   logic          any_valid;
   logic          first_wait;
   logic          wait_expired;

   // Scan downward so the requester closest after 'last' is the final (winning) assignment.
   function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [GW-1:0]      last);
      logic [GW-1:0] pick;
      int            idx;
      pick = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = int'(last) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (vld[idx[GW-1:0]]) pick = idx[GW-1:0];
      end
      return pick;
   endfunction

   always_comb begin
      winner   = rr_pick(i_req_valid, last_grant);
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (GW'(k) == winner) begin
            sel_addr = i_req_addr[k*21 +: 21];
            sel_data = i_req_data[k*64 +: 64];
         end
      end
   end

   assign any_valid    = |i_req_valid;
   assign o_req_ready  = (state == IDLE && any_valid) ? (NUM_REQ'(1) << winner) : '0;
   assign o_busy       = (state != IDLE);
   assign first_wait   = (wait_cnt == '0);
   assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= IDLE;
         last_grant        <= GW'(NUM_REQ - 1);
         wait_cnt          <= '0;
         o_grant_id        <= '0;
         o_wr_blockAddress <= '0;
         o_wr_blockPayload <= '0;
         o_wr_base_addr    <= '0;
         o_wr_init         <= 1'b0;
         o_cpl_valid       <= '0;
         o_cpl_error       <= 1'b0;
         o_timeout         <= 1'b0;
         o_write_count     <= '0;
      end else begin
         o_wr_init   <= 1'b0;
         o_cpl_valid <= '0;
         o_cpl_error <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  o_grant_id        <= winner;
                  o_wr_blockAddress <= sel_addr;
                  o_wr_blockPayload <= sel_data;
                  o_wr_base_addr    <= i_base_addr;
                  o_wr_init         <= 1'b1;
                  state             <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // A done left over from the previous transaction can still be high in the first cycle.
               if (!first_wait && i_wr_done) begin
                  o_cpl_valid <= NUM_REQ'(1) << o_grant_id;
                  o_cpl_error <= i_wr_error;
                  state       <= CPL;
               end else if (wait_expired) begin
                  o_cpl_valid <= NUM_REQ'(1) << o_grant_id;
                  o_cpl_error <= 1'b1;
                  o_timeout   <= 1'b1;
                  state       <= CPL;
               end
            end
            CPL: begin
               o_write_count <= o_write_count + 32'd1;
               last_grant    <= o_grant_id;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alib_extmem_arb.sv
// Bench for alib_extmem_arb: a cycle-driven writer stub plus a round-robin/timeout reference model.
module tb_alib_extmem_arb;
   localparam int N  = 4;
   localparam int TO = 8;
   localparam int GW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [21*N-1:0]  req_addr;
   logic [64*N-1:0]  req_data;
   logic [31:0]      base_addr;
   logic [N-1:0]     cpl_valid;
   logic             cpl_error;
   logic [20:0]      wr_addr;
   logic [63:0]      wr_data;
   logic [31:0]      wr_base;
   logic             wr_init;
   logic             wr_done;
   logic             wr_error;
   logic             busy;
   logic [GW-1:0]    grant_id;
   logic             timeout;
   logic [31:0]      write_count;

   always #5 clk = ~clk;

   alib_extmem_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_addr(req_addr), .i_req_data(req_data), .i_base_addr(base_addr),
      .o_cpl_valid(cpl_valid), .o_cpl_error(cpl_error),
      .o_wr_blockAddress(wr_addr), .o_wr_blockPayload(wr_data), .o_wr_base_addr(wr_base),
      .o_wr_init(wr_init), .i_wr_done(wr_done), .i_wr_error(wr_error),
      .o_busy(busy), .o_grant_id(grant_id), .o_timeout(timeout), .o_write_count(write_count)
   );

   int checks = 0;
   int failures = 0;

   // reference model state
   int          m_last = N - 1;
   logic [31:0] m_count = 0;
   logic [20:0] raddr [N];
   logic [63:0] rdata [N];

   // observations from one transaction
   bit          obs_found;
   logic [N-1:0] obs_ready, obs_ready_issue, obs_cpl;
   int          obs_gid, obs_cpl_idx, obs_extra_init;
   logic        obs_init, obs_busy, obs_err, obs_to;
   logic [20:0] obs_addr;
   logic [63:0] obs_data;
   logic [31:0] obs_base, obs_base_late, obs_cnt_pre;

   function automatic int rr_expect(input logic [N-1:0] m, input int last);
      int j;
      for (int i = 1; i <= N; i++) begin
         j = (last + i) % N;
         if (((m >> j) & 1) != 0) return j;
      end
      return -1;
   endfunction

   // WAIT-cycle index holding the completion pulse when fresh done is driven in WAIT cycle d
   function automatic int exp_idx(input int d);
      return (d >= 1 && d <= TO - 1) ? d + 1 : TO;
   endfunction

   task automatic pack_reqs();
      for (int k = 0; k < N; k++) begin
         req_addr[k*21 +: 21] = raddr[k];
         req_data[k*64 +: 64] = rdata[k];
      end
   endtask

   task automatic randomize_reqs();
      for (int k = 0; k < N; k++) begin
         raddr[k] = 21'($urandom);
         rdata[k] = {$urandom, $urandom};
      end
      pack_reqs();
   endtask

   task automatic apply_reset();
      rst = 1'b1; req_valid = '0; wr_done = 1'b0; wr_error = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_last = N - 1; m_count = 0;
   endtask

   // One arbitration + writer handshake; done is driven fresh in WAIT cycle d (d out of range: never).
   task automatic txn(input int d, input bit werr, input bit stale, input bit clr);
      obs_found = 0; obs_extra_init = 0; obs_cpl = '0; obs_cpl_idx = -1; obs_gid = -1;
      obs_err = 1'bx; obs_to = 1'bx;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req_ready != 0) begin obs_found = 1; break; end
         @(negedge clk);
      end
      if (!obs_found) return;
      obs_ready = req_ready; obs_cnt_pre = write_count;
      for (int i = 0; i < N; i++) if (((req_ready >> i) & 1) != 0) obs_gid = i;
      @(negedge clk);
      obs_init = wr_init; obs_ready_issue = req_ready; obs_busy = busy;
      obs_addr = wr_addr; obs_data = wr_data; obs_base = wr_base;
      if (clr) req_valid = req_valid & ~(N'(1) << obs_gid);
      base_addr = $urandom;
      if (stale) begin wr_done = 1'b1; wr_error = 1'b1; end
      for (int w = 0; w <= TO + 4; w++) begin
         @(negedge clk);
         if (wr_init) obs_extra_init++;
         if (cpl_valid != 0) begin
            obs_cpl = cpl_valid; obs_err = cpl_error; obs_cpl_idx = w;
            obs_to = timeout; obs_base_late = wr_base;
            break;
         end
         wr_done  = (stale && w == 0) || (w == d);
         wr_error = (stale && w == 0) ? 1'b1 : werr;
      end
      wr_done = 1'b0; wr_error = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (cpl_valid !== '0 || wr_init !== 1'b0) begin failures++; $display("FAIL reset_pulses got cpl=%b init=%b exp=0", cpl_valid, wr_init); end
      checks++; if (wr_addr !== '0 || wr_data !== '0 || wr_base !== '0 || grant_id !== '0) begin
         failures++; $display("FAIL reset_wr_regs got addr=%h data=%h base=%h gid=%0d exp=0", wr_addr, wr_data, wr_base, grant_id); end
      checks++; if (timeout !== 1'b0 || write_count !== 32'd0) begin failures++; $display("FAIL reset_status got to=%b cnt=%0d exp=0", timeout, write_count); end
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready_idle got=%b exp=0", req_ready); end
      req_valid = 4'b1111; #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_priority got=%b exp=0001", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_single();
      raddr[2] = 21'h00005; rdata[2] = 64'hDEADBEEF_01234567; pack_reqs();
      base_addr = 32'h4000_0000; req_valid = 4'b0100;
      txn(5, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", obs_ready); end
      checks++; if (obs_init !== 1'b1 || obs_extra_init != 0) begin failures++; $display("FAIL single_init got=%b extra=%0d exp=1/0", obs_init, obs_extra_init); end
      checks++; if (obs_ready_issue !== '0 || obs_busy !== 1'b1) begin failures++; $display("FAIL single_issue got ready=%b busy=%b exp=0/1", obs_ready_issue, obs_busy); end
      checks++; if (obs_addr !== 21'h00005 || obs_data !== 64'hDEADBEEF_01234567 || obs_base !== 32'h4000_0000) begin
         failures++; $display("FAIL single_wr got %h %h %h exp 00005 deadbeef01234567 40000000", obs_addr, obs_data, obs_base); end
      checks++; if (obs_base_late !== 32'h4000_0000) begin failures++; $display("FAIL single_base_hold got=%h exp=40000000", obs_base_late); end
      checks++; if (obs_cpl !== 4'b0100 || obs_err !== 1'b0 || obs_cpl_idx != 6) begin
         failures++; $display("FAIL single_cpl got=%b err=%b idx=%0d exp=0100 0 6", obs_cpl, obs_err, obs_cpl_idx); end
      @(negedge clk);
      checks++; if (write_count !== 32'd1 || busy !== 1'b0) begin failures++; $display("FAIL single_count got cnt=%0d busy=%b exp=1/0", write_count, busy); end
   endtask

   task automatic test_round_robin();
      int exp;
      apply_reset();
      randomize_reqs(); base_addr = $urandom; req_valid = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         exp = rr_expect(4'b1111, m_last);
         txn(int'($urandom_range(1, 5)), 1'b0, 1'b0, 1'b0);
         checks++; if (obs_gid != exp || obs_addr !== raddr[exp]) begin
            failures++; $display("FAIL rr_grant t=%0d got=%0d addr=%h exp=%0d addr=%h", t, obs_gid, obs_addr, exp, raddr[exp]); end
         checks++; if (obs_cnt_pre !== m_count) begin failures++; $display("FAIL rr_count t=%0d got=%0d exp=%0d", t, obs_cnt_pre, m_count); end
         m_last = exp; m_count++;
      end
      req_valid = '0;
      @(negedge clk);
      checks++; if (write_count !== m_count) begin failures++; $display("FAIL rr_final_count got=%0d exp=%0d", write_count, m_count); end
   endtask

   task automatic test_error();
      req_valid = 4'b0010;
      txn(3, 1'b1, 1'b0, 1'b1);
      checks++; if (obs_cpl !== 4'b0010 || obs_err !== 1'b1 || obs_to !== 1'b0) begin
         failures++; $display("FAIL err_cpl got=%b err=%b to=%b exp=0010 1 0", obs_cpl, obs_err, obs_to); end
      req_valid = 4'b1000;
      txn(2, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_cpl !== 4'b1000 || obs_err !== 1'b0 || obs_cpl_idx != 3) begin
         failures++; $display("FAIL err_recover got=%b err=%b idx=%0d exp=1000 0 3", obs_cpl, obs_err, obs_cpl_idx); end
   endtask

   task automatic test_timeout();
      req_valid = 4'b0001;
      txn(100, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_cpl !== 4'b0001 || obs_err !== 1'b1 || obs_to !== 1'b1 || obs_cpl_idx != TO) begin
         failures++; $display("FAIL timeout_cpl got=%b err=%b to=%b idx=%0d exp=0001 1 1 %0d", obs_cpl, obs_err, obs_to, obs_cpl_idx, TO); end
      req_valid = 4'b0010;
      txn(4, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_cpl !== 4'b0010 || obs_err !== 1'b0 || obs_cpl_idx != 5 || obs_to !== 1'b1) begin
         failures++; $display("FAIL timeout_next got=%b err=%b idx=%0d to=%b exp=0010 0 5 1", obs_cpl, obs_err, obs_cpl_idx, obs_to); end
      req_valid = 4'b0100;
      txn(TO - 1, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_err !== 1'b0 || obs_cpl_idx != TO) begin
         failures++; $display("FAIL timeout_done_wins got err=%b idx=%0d exp=0 %0d", obs_err, obs_cpl_idx, TO); end
   endtask

   task automatic test_stale();
      req_valid = 4'b0100;
      txn(3, 1'b0, 1'b1, 1'b1);
      checks++; if (obs_cpl !== 4'b0100 || obs_err !== 1'b0 || obs_cpl_idx != 4) begin
         failures++; $display("FAIL stale_done got=%b err=%b idx=%0d exp=0100 0 4", obs_cpl, obs_err, obs_cpl_idx); end
   endtask

   task automatic test_reset_mid();
      int hits;
      bit found;
      req_valid = 4'b0010;
      txn(2, 1'b0, 1'b0, 1'b1);
      req_valid = 4'b0100; found = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req_ready != 0) begin found = 1; break; end
         @(negedge clk);
      end
      checks++; if (!found) begin failures++; $display("FAIL rstmid_grant got=none exp=0100"); end
      @(negedge clk); req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last = N - 1; m_count = 0;
      checks++; if (busy !== 1'b0 || cpl_valid !== '0 || wr_init !== 1'b0) begin
         failures++; $display("FAIL rstmid_state got busy=%b cpl=%b init=%b exp=0", busy, cpl_valid, wr_init); end
      checks++; if (write_count !== 32'd0 || timeout !== 1'b0) begin failures++; $display("FAIL rstmid_count got cnt=%0d to=%b exp=0", write_count, timeout); end
      hits = 0; wr_done = 1'b1;
      for (int c = 0; c < 4; c++) begin @(negedge clk); wr_done = 1'b0; if (cpl_valid != 0) hits++; end
      checks++; if (hits != 0) begin failures++; $display("FAIL rstmid_no_cpl got=%0d exp=0", hits); end
      req_valid = 4'b1111;
      txn(2, 1'b0, 1'b0, 1'b0);
      req_valid = '0;
      checks++; if (obs_gid != 0) begin failures++; $display("FAIL rstmid_rr got=%0d exp=0", obs_gid); end
      m_last = 0; m_count = 1;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [N-1:0] mask;
      int d, exp;
      bit werr;
      logic [31:0] base;
      apply_reset();
      for (int t = 0; t < 24; t++) begin
         mask = N'($urandom_range(1, 15));
         randomize_reqs();
         base = $urandom; base_addr = base;
         d = int'($urandom_range(1, 10));
         werr = 1'($urandom);
         exp = rr_expect(mask, m_last);
         req_valid = mask;
         txn(d, werr, 1'b0, 1'b0);
         checks++; if (obs_gid != exp || obs_addr !== raddr[exp] || obs_data !== rdata[exp] || obs_base !== base) begin
            failures++; $display("FAIL rand_grant t=%0d got=%0d %h %h %h exp=%0d %h %h %h", t, obs_gid, obs_addr, obs_data, obs_base, exp, raddr[exp], rdata[exp], base); end
         checks++; if (obs_cpl !== (N'(1) << exp) || obs_cpl_idx != exp_idx(d) || obs_err !== ((d <= TO - 1) ? werr : 1'b1) || obs_cnt_pre !== m_count) begin
            failures++; $display("FAIL rand_cpl t=%0d got=%b idx=%0d err=%b cnt=%0d exp idx=%0d cnt=%0d", t, obs_cpl, obs_cpl_idx, obs_err, obs_cnt_pre, exp_idx(d), m_count); end
         m_last = exp; m_count++;
      end
      req_valid = '0;
      @(negedge clk);
      checks++; if (write_count !== m_count) begin failures++; $display("FAIL rand_final_count got=%0d exp=%0d", write_count, m_count); end
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; base_addr = '0;
      wr_done = 1'b0; wr_error = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_error();
      test_timeout();
      test_stale();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alib_extmem_arb.md
# alib_extmem_arb

Round-robin arbiter and sequencer that shares one `alib_extmem` single-beat 64-bit AXI writer among `NUM_REQ` requesters. Each cycle it can accept one (block address, payload) request over a valid/ready handshake and hold it stable. It then issues the writer's one-cycle init pulse, waits for the writer's done flag or a timeout, and routes a completion pulse with error status back to the originating requester. It sits between the accelerator-side producers and the `alib_extmem` instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT`, default 1024: maximum number of WAIT cycles before abort, at least 4.
- `GW`, derived as clog2(`NUM_REQ`): grant index width.

Ports. One clock; reset is synchronous and active-high.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_req_valid`  in  `NUM_REQ`  per-requester request valid.
- `o_req_ready`  out  `NUM_REQ`  per-requester accept (one-hot or zero).
- `i_req_addr`  in  21*`NUM_REQ`  block addresses; requester k is at [21k+20:21k].
- `i_req_data`  in  64*`NUM_REQ`  payloads; requester k is at [64k+63:64k].
- `i_base_addr`  in  32  external memory base address.
- `o_cpl_valid`  out  `NUM_REQ`  one-cycle completion pulse, one-hot.
- `o_cpl_error`  out  1  error status, qualified by any `o_cpl_valid` bit.
- `o_wr_blockAddress`  out  21  to writer `i_blockAddress`.
- `o_wr_blockPayload`  out  64  to writer `i_blockPayload`.
- `o_wr_base_addr`  out  32  to writer `i_alib_extmem_base_addr`.
- `o_wr_init`  out  1  to writer `i_initWriteTxn`.
- `i_wr_done`  in  1  from writer `o_writeTxnDone`.
- `i_wr_error`  in  1  from writer `o_error`.
- `o_busy`  out  1  high whenever the FSM is not IDLE.
- `o_grant_id`  out  `GW`  index of the current or most recent grant.
- `o_timeout`  out  1  sticky; set when any timeout has occurred.
- `o_write_count`  out  32  completed transactions; wraps modulo 2^32.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CPL.
- **IDLE**
  - Winner is the first asserted `i_req_valid` bit, searching upward from `last_grant`+1 with wrap-around modulo `NUM_REQ`.
  - `o_req_ready` is combinational: only the winner's bit is high, and only in IDLE.
  - On handshake:
    - latch addr, data, `i_base_addr` and the winner index into the `o_wr_*` registers and `o_grant_id`;
    - go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - `o_wr_init`=1 for exactly this cycle.
  - Clear the wait counter.
  - Go to WAIT.
- **WAIT**
  - The wait counter increments every cycle.
  - `i_wr_done` is ignored in the first WAIT cycle. From the second cycle on, `i_wr_done`=1 captures `err`=`i_wr_error` and moves to CPL.
  - If the counter reaches `TIMEOUT` with no done:
    - `err`=1 and `o_timeout` is set;
    - go to CPL.
    - The writer is not reset here. The next `o_wr_init` pulse re-initialises it.
  - If done and timeout occur in the same cycle, done wins and `err`=`i_wr_error`.
- **CPL**
  - `o_cpl_valid[grant]`=1 and `o_cpl_error`=`err` for this cycle only.
  - `o_write_count`+1, including timed-out transactions.
  - `last_grant` ← grant.
  - Go to IDLE.
- `o_wr_blockAddress`, `o_wr_blockPayload` and `o_wr_base_addr` hold constant from the handshake until the next handshake. Changes on `i_base_addr` outside IDLE are ignored.
- Requesters must hold addr and data stable while valid is high. A requester may drop valid before it is granted.

## Timing
- Reset values:
  - FSM in IDLE;
  - all outputs 0 (`o_req_ready` follows combinationally from valid);
  - `last_grant`=`NUM_REQ`-1, so requester 0 has priority first;
  - `o_timeout`=0, `o_write_count`=0.
- Reset mid-transaction:
  - return to IDLE next edge with no completion pulse;
  - `o_wr_init` low.
- Latency, with handshake at edge T:
  - `o_wr_init` high during cycle T+1;
  - WAIT begins at T+2;
  - if done is first sampled high in cycle W, `o_cpl_valid` is high in cycle W+1;
  - next `o_req_ready` no earlier than W+2.
- Throughput is at most one transaction per (writer latency + 4) cycles.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`NUM_REQ`-1,0,…

## Test plan
- **Single request.** After reset, req 2 valid with addr=0x00005, data=0xDEADBEEF_01234567, base=0x4000_0000; writer model asserts done 6 cycles after init.
  - Expect one `o_req_ready[2]`, one `o_wr_init` pulse, and `o_wr_*` equal to the inputs.
  - Expect `o_cpl_valid`=4'b0100 with error=0, and count=1.
- **Round-robin.** All 4 requesters valid continuously for 8 transactions.
  - Grant order must be 0,1,2,3,0,1,2,3 with no repeats while others wait.
- **Error path.** Writer asserts done with error=1.
  - Expect `o_cpl_error`=1 on the completion pulse.
  - The next transaction must report error=0 when the writer reports 0.
- **Timeout.** `TIMEOUT`=8; writer never asserts done.
  - Completion pulse arrives 8 WAIT cycles after the start of WAIT, with error=1 and `o_timeout`=1.
  - The next request still completes normally.
- **Stale done.** `i_wr_done` is held high from a previous transaction during the first WAIT cycle.
  - It must be ignored; completion occurs only on the writer's fresh done.
- **Reset mid-WAIT.** Assert `i_rst` for 1 cycle during WAIT.
  - No `o_cpl_valid`, `o_busy`=0 next cycle, count=0.
  - Requester 0 wins the next arbitration.
